axi_sram_read_responder: RTL and testbench
==========================================

# axi_sram_read_responder

AXI slave-side read responder placed in front of each synchronous single-port SRAM slave (S0–S4) on the interconnect. It accepts one read request at a time on the AR channel and reads each beat from the SRAM. It then drives the R channel (RID/RDATA/RRESP/RLAST/RVALID) that the interconnect read data channel multiplexes back to the masters. Bursts of 1–16 beats are supported, with FIXED, INCR and WRAP addressing and full RREADY backpressure.

## Interface
- DATA_W, 32, data width; only 32 is supported.
- IDS_W, 8, slave-side ID width.
- MEM_AW, 14, SRAM word-address width.
- Reset is ARESETn, asynchronous, active-low; the clock is ACLK.
- ACLK  in  1  clock
- ARESETn  in  1  asynchronous active-low reset
- ARID  in  IDS_W  request ID
- ARADDR  in  32  byte address
- ARLEN  in  4  beats minus 1
- ARSIZE  in  3  beat size; 3'b010 is the only legal value
- ARBURST  in  2  burst type: 00 FIXED, 01 INCR, 10 WRAP
- ARVALID  in  1  request valid
- ARREADY  out  1  request accepted
- RID  out  IDS_W  echoed ID
- RDATA  out  32  read data
- RRESP  out  2  response: 00 OKAY, 10 SLVERR
- RLAST  out  1  final beat of the burst
- RVALID  out  1  beat valid
- RREADY  in  1  master accepts the beat
- mem_cs  out  1  SRAM read strobe
- mem_addr  out  MEM_AW  SRAM word address, equal to addr_q[MEM_AW+1:2]
- mem_rdata  in  32  SRAM data, valid the cycle after mem_cs

## Operation
- FSM states: IDLE, FETCH, LOAD, RESP.
- IDLE
  - ARREADY=1.
  - On ARVALID&ARREADY, latch id_q, addr_q, len_q, burst_q, err_q; clear beat_cnt; go to FETCH.
  - err_q is set when ARBURST==2'b11 or ARSIZE!=3'b010.
- FETCH
  - mem_cs=1 unless err_q; mem_addr taken from addr_q.
  - Always go to LOAD.
- LOAD
  - Capture rdata_q <= err_q ? 0 : mem_rdata; go to RESP.
- RESP
  - RVALID=1, RDATA=rdata_q, RID=id_q, RRESP = err_q ? 2'b10 : 2'b00, RLAST = (beat_cnt==len_q).
  - On RREADY with RLAST, go to IDLE.
  - On RREADY without RLAST, advance addr_q, increment beat_cnt, go to FETCH.
  - With RREADY=0, hold every R output stable.
- ARREADY=0 in every state other than IDLE; only one burst is outstanding at a time.
- Address advance (byte address, 4-byte beats):
  - FIXED: addr_q is unchanged.
  - INCR: addr_q += 4; bits above 31 are dropped (wrap at 2^32).
  - WRAP: wrap length is L = (len_q+1)*4 and the boundary is addr_q & ~(L-1). The next address is boundary | ((addr_q+4) & (L-1)).
  - WRAP with len_q not in {1,3,7,15} sets err_q at accept time.
- Error bursts still return exactly len_q+1 beats, each with RDATA=0, RRESP=SLVERR, and mem_cs never asserted.
- ARADDR bits above MEM_AW+1 are ignored; address decode belongs to the interconnect.

## Timing
- Reset values: ARREADY=1 (state IDLE), RVALID=0, RLAST=0, RID=0, RDATA=0, RRESP=0, mem_cs=0, beat_cnt=0.
- Latency: AR handshake at edge 0, then FETCH in cycle 1, LOAD in cycle 2, RVALID high from cycle 3.
- Throughput: one beat per 3 cycles when RREADY is held high. A 16-beat burst takes 48 cycles from handshake to the last R handshake.
- ARREADY is high in the cycle after the last R handshake, because the state is IDLE again.
- Back-to-back request: ARVALID held continuously is accepted in the first IDLE cycle.
- RVALID never drops without RREADY, and RDATA/RID/RRESP/RLAST never change while RVALID=1 and RREADY=0.
- RREADY high outside RESP has no effect.
- Reset mid-burst: ARESETn low forces IDLE and reset values immediately (asynchronously). The remaining beats are discarded and no RLAST is issued.
- beat_cnt is 4 bits wide and never exceeds len_q.

## Test plan
- Single-beat INCR: SRAM word 0x004=0xDEADBEEF; AR with ARID=0x25, ARADDR=0x10, ARLEN=0.
  - Required: mem_cs in cycle 1 with mem_addr=4.
  - Required: RVALID in cycle 3 with RDATA=0xDEADBEEF, RLAST=1, RRESP=0, RID=0x25; ARREADY=1 the cycle after.
- 4-beat INCR at ARADDR=0x100 with RREADY toggling 1,0,0,1.
  - Required: words 0x40–0x43 returned in order.
  - Required: outputs stable across the stall cycles; RLAST only on beat 4.
- WRAP burst, ARLEN=3, ARADDR=0x38.
  - Required: mem_addr sequence 0xE, 0xF, 0xC, 0xD; RLAST on the 4th beat.
- FIXED burst, ARLEN=2, ARADDR=0x20.
  - Required: three beats, all reading mem_addr=8.
- Error requests: ARBURST=2'b11 with ARLEN=1, then ARSIZE=3'b001 with ARLEN=0.
  - Required: 2 beats and then 1 beat of RRESP=2'b10 with RDATA=0; mem_cs is never asserted.
- Reset during beat 2 of an 8-beat INCR burst, with RREADY=0.
  - Required: RVALID=0 immediately and ARREADY=1 after release.
  - Required: a new single-beat request then completes normally with RID equal to the new ARID.

Source files
------------

// File: rtl/axi_sram_read_responder_if.sv
// AXI read-channel bundle (AR + R) between the interconnect and an SRAM responder.
// slave modport faces the responder; master modport faces the requester.
interface axi_sram_read_responder_if #(
  parameter int DATA_W = 32,
  parameter int IDS_W  = 8
);
  logic [IDS_W-1:0]  ARID;
  logic [31:0]       ARADDR;
  logic [3:0]        ARLEN;
  logic [2:0]        ARSIZE;
  logic [1:0]        ARBURST;
  logic              ARVALID;
  logic              ARREADY;
  logic [IDS_W-1:0]  RID;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;
  logic              RLAST;
  logic              RVALID;
  logic              RREADY;

  modport slave (
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID,
    input  RREADY
  );

  modport master (
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID,
    output RREADY
  );
endinterface

// File: rtl/axi_sram_read_responder.sv
// AXI read responder for a single-port sync SRAM: one burst at a time, 3 cycles/beat.
// Ports: ACLK, ARESETn, bus (AR/R slave), mem_cs/mem_addr to SRAM, mem_rdata from SRAM.
module axi_sram_read_responder #(
  parameter int DATA_W = 32,
  parameter int IDS_W  = 8,
  parameter int MEM_AW = 14
) (
  input  logic                      ACLK,
  input  logic                      ARESETn,
  axi_sram_read_responder_if.slave  bus,
  output logic                      mem_cs,
  output logic [MEM_AW-1:0]         mem_addr,
  input  logic [DATA_W-1:0]         mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    LOAD,
    RESP
  } state_t;

  state_t            state;
  logic [IDS_W-1:0]  id_q;
  logic [31:0]       addr_q;
  logic [3:0]        len_q;
  logic [1:0]        burst_q;
  logic              err_q;
  logic [3:0]        beat_cnt;
  logic [DATA_W-1:0] rdata_q;
  logic              arready_q;
  logic              rvalid_q;
  logic              rlast_q;
  logic              cs_q;

  logic              wrap_bad;
  logic              req_err;

  // WRAP needs a power-of-two beat count
  assign wrap_bad = (bus.ARBURST == 2'b10) &&
                    (bus.ARLEN != 4'd1)  &&
                    (bus.ARLEN != 4'd3)  &&
                    (bus.ARLEN != 4'd7)  &&
                    (bus.ARLEN != 4'd15);

  assign req_err = (bus.ARBURST == 2'b11) ||
                   (bus.ARSIZE != 3'b010) ||
                   wrap_bad;

  // Wrap mask is L-1 with L=(len+1)*4, i.e. {len,2'b11} for legal lengths
  function automatic logic [31:0] next_addr(
    input logic [31:0] a,
    input logic [3:0]  len,
    input logic [1:0]  burst
  );
    logic [31:0] mask;
    logic [31:0] inc;
    mask = {26'd0, len, 2'b11};
    inc  = a + 32'd4;
    unique case (burst)
      2'b01:   next_addr = inc;
      2'b10:   next_addr = (a & ~mask) | (inc & mask);
      default: next_addr = a;
    endcase
  endfunction

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state     <= IDLE;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      burst_q   <= '0;
      err_q     <= 1'b0;
      beat_cnt  <= '0;
      rdata_q   <= '0;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      cs_q      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.ARVALID) begin
            id_q      <= bus.ARID;
            addr_q    <= bus.ARADDR;
            len_q     <= bus.ARLEN;
            burst_q   <= bus.ARBURST;
            err_q     <= req_err;
            beat_cnt  <= '0;
            arready_q <= 1'b0;
            cs_q      <= !req_err;
            state     <= FETCH;
          end
        end
        FETCH: begin
          cs_q  <= 1'b0;
          state <= LOAD;
        end
        LOAD: begin
          rdata_q  <= err_q ? '0 : mem_rdata;
          rvalid_q <= 1'b1;
          rlast_q  <= (beat_cnt == len_q);
          state    <= RESP;
        end
        RESP: begin
          if (bus.RREADY) begin
            rvalid_q <= 1'b0;
            if (rlast_q) begin
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
              state     <= IDLE;
            end else begin
              addr_q   <= next_addr(addr_q, len_q, burst_q);
              beat_cnt <= beat_cnt + 4'd1;
              cs_q     <= !err_q;
              state    <= FETCH;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ARREADY = arready_q;
  assign bus.RVALID  = rvalid_q;
  assign bus.RLAST   = rlast_q;
  assign bus.RID     = id_q;
  assign bus.RDATA   = rdata_q;
  assign bus.RRESP   = err_q ? 2'b10 : 2'b00;
  assign mem_cs      = cs_q;
  assign mem_addr    = addr_q[MEM_AW+1:2];

endmodule

// File: tb/tb_axi_sram_read_responder.sv
// Directed + randomized bench for axi_sram_read_responder.
// Reference model computes beat addresses/data arithmetically per burst type.
module tb_axi_sram_read_responder;

  logic        ACLK;
  logic        ARESETn;
  logic        mem_cs;
  logic [13:0] mem_addr;
  logic [31:0] mem_rdata;
  logic [31:0] sram [0:16383];

  int checks = 0;
  int errors = 0;
  int pat [4] = '{1, 0, 0, 1};

  axi_sram_read_responder_if #(.DATA_W(32), .IDS_W(8)) bus ();

  axi_sram_read_responder #(
    .DATA_W(32),
    .IDS_W (8),
    .MEM_AW(14)
  ) dut (
    .ACLK     (ACLK),
    .ARESETn  (ARESETn),
    .bus      (bus),
    .mem_cs   (mem_cs),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  always @(posedge ACLK)
    if (mem_cs) mem_rdata <= sram[mem_addr];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_err(input logic [3:0] len, input logic [2:0] size,
                                input logic [1:0] burst);
    bit wl;
    wl = (len == 1) || (len == 3) || (len == 7) || (len == 15);
    return (burst == 2'b11) || (size != 3'b010) || (burst == 2'b10 && !wl);
  endfunction

  // Byte address of beat i, straight from the burst-type definitions
  function automatic logic [31:0] beat_addr(input logic [31:0] a,
                                            input logic [3:0] len,
                                            input logic [1:0] burst,
                                            input int i);
    longint unsigned L, base, off;
    case (burst)
      2'b01: return a + 32'(4 * i);
      2'b10: begin
        L    = (longint'(len) + 1) * 4;
        base = a - (a % L);
        off  = (a - base + 4 * i) % L;
        return 32'(base + off);
      end
      default: return a;
    endcase
  endfunction

  task automatic issue_ar(input logic [7:0] id, input logic [31:0] addr,
                          input logic [3:0] len, input logic [2:0] size,
                          input logic [1:0] burst);
    @(negedge ACLK);
    bus.ARID    = id;
    bus.ARADDR  = addr;
    bus.ARLEN   = len;
    bus.ARSIZE  = size;
    bus.ARBURST = burst;
    bus.ARVALID = 1'b1;
    chk("arready_idle", bus.ARREADY, 1'b1);
    @(posedge ACLK);
    #1 bus.ARVALID = 1'b0;
  endtask

  // mode 0: RREADY always 1, 1: random, 2: pattern 1,0,0,1
  task automatic run_burst(input logic [7:0] id, input logic [31:0] addr,
                           input logic [3:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input int mode);
    logic [31:0] exp_a [$];
    logic [13:0] got [$];
    logic [31:0] ed, pd;
    logic [7:0]  pid;
    logic [1:0]  presp;
    logic        plast, rr;
    bit err, stalled, seen, done;
    int k, n, pidx, last_k;
    err = is_err(len, size, burst);
    for (int i = 0; i <= int'(len); i++)
      exp_a.push_back(beat_addr(addr, len, burst, i));
    issue_ar(id, addr, len, size, burst);
    k = 0; n = 0; pidx = 0; last_k = 0;
    stalled = 0; seen = 0; done = 0;
    pd = '0; pid = '0; presp = '0; plast = 0;
    while (!done && k < 400) begin
      @(negedge ACLK);
      k++;
      if (mem_cs === 1'b1) got.push_back(mem_addr);
      if (k == 1) chk("cs_cycle1", mem_cs, !err);
      if (stalled) begin
        chk("hold_valid", bus.RVALID, 1'b1);
        chk("hold_data", bus.RDATA, pd);
        chk("hold_id", bus.RID, pid);
        chk("hold_resp", bus.RRESP, presp);
        chk("hold_last", bus.RLAST, plast);
      end
      if (bus.RVALID === 1'b1) begin
        if (!seen) begin
          chk("latency", k, 3);
          seen = 1;
        end
        ed = err ? 32'd0 : sram[exp_a[n][15:2]];
        chk("rdata", bus.RDATA, ed);
        chk("rid", bus.RID, id);
        chk("rresp", bus.RRESP, err ? 2'b10 : 2'b00);
        chk("rlast", bus.RLAST, n == int'(len));
        if (mode == 0) rr = 1'b1;
        else if (mode == 1) rr = 1'($urandom_range(0, 1));
        else rr = 1'(pat[pidx % 4]);
        pidx++;
        bus.RREADY = rr;
        pd = bus.RDATA; pid = bus.RID;
        presp = bus.RRESP; plast = bus.RLAST;
        stalled = !rr;
        if (rr) begin
          n++;
          if (n == int'(len) + 1) begin
            done = 1;
            last_k = k;
          end
        end
      end else begin
        bus.RREADY = 1'($urandom_range(0, 1));
        stalled = 0;
      end
    end
    chk("burst_done", done, 1'b1);
    if (mode == 0) chk("throughput", last_k, 3 * (int'(len) + 1));
    @(posedge ACLK);
    #1 bus.RREADY = 1'b0;
    @(negedge ACLK);
    chk("arready_after", bus.ARREADY, 1'b1);
    chk("rvalid_after", bus.RVALID, 1'b0);
    if (err) begin
      chk("err_no_cs", got.size(), 0);
    end else begin
      chk("cs_count", got.size(), int'(len) + 1);
      for (int i = 0; i < got.size() && i <= int'(len); i++)
        chk("mem_addr", got[i], exp_a[i][15:2]);
    end
  endtask

  initial begin
    logic [1:0] b;
    logic [3:0] l;
    logic [2:0] s;
    int cnt, w;
    bit hit;
    for (int i = 0; i < 16384; i++) sram[i] = $urandom;
    sram[4] = 32'hDEADBEEF;
    ARESETn = 1'b0;
    bus.ARVALID = 1'b0;
    bus.ARID = '0; bus.ARADDR = '0; bus.ARLEN = '0;
    bus.ARSIZE = 3'b010; bus.ARBURST = 2'b01;
    bus.RREADY = 1'b0;
    #12;
    chk("rst_arready", bus.ARREADY, 1'b1);
    chk("rst_rvalid", bus.RVALID, 1'b0);
    chk("rst_rlast", bus.RLAST, 1'b0);
    chk("rst_rid", bus.RID, 8'h00);
    chk("rst_rdata", bus.RDATA, 32'h0);
    chk("rst_rresp", bus.RRESP, 2'b00);
    chk("rst_mem_cs", mem_cs, 1'b0);
    @(negedge ACLK);
    ARESETn = 1'b1;

    run_burst(8'h25, 32'h0000_0010, 4'd0, 3'b010, 2'b01, 0);
    run_burst(8'h11, 32'h0000_0100, 4'd3, 3'b010, 2'b01, 2);
    run_burst(8'h12, 32'h0000_0038, 4'd3, 3'b010, 2'b10, 0);
    run_burst(8'h13, 32'h0000_0020, 4'd2, 3'b010, 2'b00, 0);
    run_burst(8'h14, 32'h0000_0040, 4'd1, 3'b010, 2'b11, 0);
    run_burst(8'h15, 32'h0000_0044, 4'd0, 3'b001, 2'b01, 0);
    run_burst(8'h16, 32'h0000_0080, 4'd15, 3'b010, 2'b01, 0);
    run_burst(8'h17, 32'hFFFF_FFF8, 4'd3, 3'b010, 2'b01, 1);
    run_burst(8'h18, 32'h0000_0064, 4'd2, 3'b010, 2'b10, 0);

    // Reset while beat 2 of an 8-beat INCR is stalled
    issue_ar(8'h33, 32'h0000_0200, 4'd7, 3'b010, 2'b01);
    cnt = 0; w = 0; hit = 0;
    while (!hit && w < 100) begin
      @(negedge ACLK);
      w++;
      if (bus.RVALID === 1'b1) begin
        cnt++;
        if (cnt == 1) bus.RREADY = 1'b1;
        else begin
          bus.RREADY = 1'b0;
          hit = 1;
        end
      end else bus.RREADY = 1'b0;
    end
    chk("reset_reach_beat2", hit, 1'b1);
    #2 ARESETn = 1'b0;
    #1;
    chk("reset_rvalid", bus.RVALID, 1'b0);
    chk("reset_rlast", bus.RLAST, 1'b0);
    chk("reset_arready", bus.ARREADY, 1'b1);
    @(negedge ACLK);
    ARESETn = 1'b1;
    @(negedge ACLK);
    chk("post_rst_arready", bus.ARREADY, 1'b1);
    chk("post_rst_rvalid", bus.RVALID, 1'b0);
    run_burst(8'h5A, 32'h0000_0300, 4'd0, 3'b010, 2'b01, 0);

    for (int t = 0; t < 24; t++) begin
      b = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 7) == 0) b = 2'b11;
      l = 4'($urandom_range(0, 15));
      if (b == 2'b10 && $urandom_range(0, 5) != 0) begin
        case ($urandom_range(0, 3))
          0: l = 4'd1;
          1: l = 4'd3;
          2: l = 4'd7;
          default: l = 4'd15;
        endcase
      end
      s = 3'b010;
      if ($urandom_range(0, 7) == 0) s = 3'($urandom_range(0, 7));
      run_burst(8'($urandom), $urandom & 32'hFFFF_FFFC, l, s, b,
                int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
